// File: rtl/neurex_pkg.sv
// rtl/neurex_pkg.sv - shared types, widths and helpers for the Neurex accelerator
package neurex_pkg;

  // Beat, cycle and tile counters are kept at a fixed generous width
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DONE
  } state_t;

  // Accumulator width for a DATA_WIDTH x DATA_WIDTH product
  function automatic int psum_width(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/neurex_pe.sv
// rtl/neurex_pe.sv - systolic MAC processing element with A/B pass-through
module neurex_pe #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [PSUM_WIDTH-1:0] acc
);

  logic [PSUM_WIDTH-1:0] prod;

  assign prod = PSUM_WIDTH'(a_in) * PSUM_WIDTH'(b_in);

  // Forward operands one hop and accumulate; clr starts a new tile
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= clr ? '0 : acc + prod;
    end
  end

endmodule

// File: rtl/neurex_top.sv
// rtl/neurex_top.sv - output-stationary systolic matrix-multiply accelerator
module neurex_top
  import neurex_pkg::*;
#(
  parameter int SYS_ROW    = 4,
  parameter int SYS_COL    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int ACCUM_SIZE = 32,
  localparam int PSUM_WIDTH = psum_width(DATA_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [DATA_WIDTH-1:0]                num_in,
  input  logic [DATA_WIDTH-1:0]                num_common,
  input  logic [DATA_WIDTH-1:0]                num_out,
  input  logic                                 in_en,
  input  logic                                 w_en,
  input  logic [SYS_ROW-1:0][DATA_WIDTH-1:0]   in_data,
  input  logic [SYS_COL-1:0][DATA_WIDTH-1:0]   w_data,
  output logic [SYS_COL-1:0][PSUM_WIDTH-1:0]   out_rd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OB_AW = $clog2(ACCUM_SIZE);
  localparam int LAT   = SYS_ROW + SYS_COL - 1;

  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] n_in, n_com, n_out, j_in, j_com, j_out;
  logic [CNT_W-1:0] in_cnt, w_cnt, in_idx, w_idx, in_tgt, w_tgt;
  logic [CNT_W-1:0] cyc, rb, cb, k, rd_in_addr, rd_w_addr;
  logic start, in_acc, w_acc, issued_all, active, streaming, clr, push_cyc, push, pop;

  logic [SYS_ROW-1:0][DATA_WIDTH-1:0] in_mem [2**ADDR_WIDTH];
  logic [SYS_COL-1:0][DATA_WIDTH-1:0] w_mem  [2**ADDR_WIDTH];
  logic [SYS_COL-1:0][PSUM_WIDTH-1:0] obuf   [ACCUM_SIZE];

  logic [SYS_ROW-1:0][DATA_WIDTH-1:0] feed_a;
  logic [SYS_COL-1:0][DATA_WIDTH-1:0] feed_b;
  logic [DATA_WIDTH-1:0] a_sk [SYS_ROW][SYS_ROW];
  logic [DATA_WIDTH-1:0] b_sk [SYS_COL][SYS_COL];
  logic [DATA_WIDTH-1:0] a_h  [SYS_ROW][SYS_COL+1];
  logic [DATA_WIDTH-1:0] b_v  [SYS_ROW+1][SYS_COL];
  logic [SYS_COL-1:0][PSUM_WIDTH-1:0] acc_arr [SYS_ROW];

  logic [SYS_COL-1:0][PSUM_WIDTH-1:0] f_data [FIFO_DEPTH];
  logic [CNT_W-1:0] f_addr [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [FC_W-1:0]  f_cnt;
  logic [PTR_W-1:0] push_idx  [SYS_ROW];
  logic [CNT_W-1:0] push_addr [SYS_ROW];

  // The first beat of a job carries the dimensions, so use the live ports on that beat
  assign start  = (state == ST_IDLE || state == ST_DONE) && (in_en || w_en);
  assign j_in   = start ? num_in     : n_in;
  assign j_com  = start ? num_common : n_com;
  assign j_out  = start ? num_out    : n_out;
  assign in_tgt = CNT_W'(j_in) * CNT_W'(j_com) / CNT_W'(SYS_ROW);
  assign w_tgt  = CNT_W'(j_com) * CNT_W'(j_out) / CNT_W'(SYS_COL);
  assign in_idx = start ? '0 : in_cnt;
  assign w_idx  = start ? '0 : w_cnt;
  assign in_acc = in_en && (start || state == ST_LOAD) && (in_idx < in_tgt);
  assign w_acc  = w_en  && (start || state == ST_LOAD) && (w_idx  < w_tgt);

  // Tile sequencing: cycle 0 clears, 1..n_com stream, n_com+LAT pushes results
  assign active     = (state == ST_COMPUTE) && !issued_all;
  assign k          = cyc - 1'b1;
  assign streaming  = active && (cyc != '0) && (cyc <= CNT_W'(n_com));
  assign clr        = active && (cyc == '0);
  assign push_cyc   = active && (cyc == CNT_W'(n_com) + CNT_W'(LAT));
  assign push       = push_cyc && (32'(f_cnt) + SYS_ROW <= FIFO_DEPTH);
  assign pop        = (f_cnt != '0);
  assign rd_in_addr = rb * CNT_W'(n_com) + k;
  assign rd_w_addr  = cb * CNT_W'(n_com) + k;
  assign feed_a     = streaming ? in_mem[rd_in_addr[ADDR_WIDTH-1:0]] : '0;
  assign feed_b     = streaming ? w_mem[rd_w_addr[ADDR_WIDTH-1:0]]   : '0;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start) state_nx = ST_LOAD;
      ST_LOAD:    if (in_cnt == in_tgt && w_cnt == w_tgt) state_nx = ST_COMPUTE;
      ST_COMPUTE: if (issued_all && f_cnt == '0) state_nx = ST_DONE;
      ST_DONE:    if (start) state_nx = ST_LOAD;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Job dimensions, load counters and tile counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_in <= '0; n_com <= '0; n_out <= '0;
      in_cnt <= '0; w_cnt <= '0;
      cyc <= '0; rb <= '0; cb <= '0; issued_all <= 1'b0;
    end else begin
      if (start) begin
        n_in <= num_in; n_com <= num_common; n_out <= num_out;
        cyc <= '0; rb <= '0; cb <= '0; issued_all <= 1'b0;
      end else if (active && !push_cyc) begin
        cyc <= cyc + 1'b1;
      end else if (push) begin
        cyc <= '0;
        if (cb == CNT_W'(n_out) / CNT_W'(SYS_COL) - 1'b1) begin
          cb <= '0;
          if (rb == CNT_W'(n_in) / CNT_W'(SYS_ROW) - 1'b1) issued_all <= 1'b1;
          else rb <= rb + 1'b1;
        end else begin
          cb <= cb + 1'b1;
        end
      end
      in_cnt <= in_idx + CNT_W'(in_acc);
      w_cnt  <= w_idx + CNT_W'(w_acc);
    end
  end

  // Scratchpad writes (contents are don't-care across reset)
  always_ff @(posedge clk) begin
    if (in_acc) in_mem[in_idx[ADDR_WIDTH-1:0]] <= in_data;
    if (w_acc)  w_mem[w_idx[ADDR_WIDTH-1:0]]   <= w_data;
  end

  // Skew lines: row r sees its input r cycles late, column c its weight c cycles late
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_sk <= '{default: '0};
      b_sk <= '{default: '0};
    end else begin
      for (int r = 0; r < SYS_ROW; r++) begin
        a_sk[r][0] <= feed_a[r];
        for (int s = 1; s < SYS_ROW; s++) a_sk[r][s] <= a_sk[r][s-1];
      end
      for (int c = 0; c < SYS_COL; c++) begin
        b_sk[c][0] <= feed_b[c];
        for (int s = 1; s < SYS_COL; s++) b_sk[c][s] <= b_sk[c][s-1];
      end
    end
  end

  for (genvar r = 0; r < SYS_ROW; r++) begin : g_west
    if (r == 0) begin : g_first
      assign a_h[r][0] = feed_a[r];
    end else begin : g_skew
      assign a_h[r][0] = a_sk[r][r-1];
    end
  end

  for (genvar c = 0; c < SYS_COL; c++) begin : g_north
    if (c == 0) begin : g_first
      assign b_v[0][c] = feed_b[c];
    end else begin : g_skew
      assign b_v[0][c] = b_sk[c][c-1];
    end
  end

  for (genvar r = 0; r < SYS_ROW; r++) begin : g_row
    for (genvar c = 0; c < SYS_COL; c++) begin : g_col
      neurex_pe #(.DATA_WIDTH(DATA_WIDTH), .PSUM_WIDTH(PSUM_WIDTH)) u_pe (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .a_in  (a_h[r][c]),
        .b_in  (b_v[r][c]),
        .a_out (a_h[r][c+1]),
        .b_out (b_v[r+1][c]),
        .acc   (acc_arr[r][c])
      );
    end
  end

  // FIFO slot and output-word address for each result row of the current tile
  always_comb begin
    for (int r = 0; r < SYS_ROW; r++) begin
      push_idx[r]  = PTR_W'((int'(wr_ptr) + r) % FIFO_DEPTH);
      push_addr[r] = (rb * CNT_W'(SYS_ROW) + CNT_W'(r)) * (CNT_W'(n_out) / CNT_W'(SYS_COL)) + cb;
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'((int'(wr_ptr) + SYS_ROW) % FIFO_DEPTH);
      if (pop)  rd_ptr <= PTR_W'((int'(rd_ptr) + 1) % FIFO_DEPTH);
      f_cnt <= f_cnt + (push ? FC_W'(SYS_ROW) : '0) - FC_W'(pop);
    end
  end

  // Result FIFO storage and output-buffer writes
  always_ff @(posedge clk) begin
    if (push) begin
      for (int r = 0; r < SYS_ROW; r++) begin
        f_data[push_idx[r]] <= acc_arr[r];
        f_addr[push_idx[r]] <= push_addr[r];
      end
    end
    if (pop && f_addr[rd_ptr] < CNT_W'(ACCUM_SIZE))
      obuf[f_addr[rd_ptr][OB_AW-1:0]] <= f_data[rd_ptr];
  end

  // Mirror of the last output word written, even when the write was out of range
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    out_rd_data <= '0;
    else if (pop) out_rd_data <= f_data[rd_ptr];
  end

endmodule

// File: tb/tb_neurex_top.sv
// tb/tb_neurex_top.sv - directed self-checking bench for neurex_top
module tb_neurex_top;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [15:0]       num_in = '0, num_common = '0, num_out = '0;
  logic              in_en = 1'b0, w_en = 1'b0;
  logic [3:0][15:0]  in_data = '0, w_data = '0;
  logic [3:0][31:0]  out_rd_data;

  int checks = 0;
  int failures = 0;

  logic [3:0][31:0] last_seen = '0;
  logic [3:0][31:0] seen_q [$];

  neurex_top dut (
    .clk         (clk),
    .rstn        (rstn),
    .num_in      (num_in),
    .num_common  (num_common),
    .num_out     (num_out),
    .in_en       (in_en),
    .w_en        (w_en),
    .in_data     (in_data),
    .w_data      (w_data),
    .out_rd_data (out_rd_data)
  );

  always #5 clk = ~clk;

  // Record every new output word
  always @(negedge clk) begin
    if (out_rd_data !== last_seen) begin
      seen_q.push_back(out_rd_data);
      last_seen = out_rd_data;
    end
  end

  // Default job row idx in write order (rb outer, cb inner, r innermost)
  function automatic logic [3:0][31:0] exp_default(input int idx);
    logic [3:0][31:0] v;
    int r, cb;
    r  = idx % 4;
    cb = (idx / 4) % 4;
    for (int c = 0; c < 4; c++) v[c] = 32'((8*r + 24) * (cb*8 + c) + 28*r + 92);
    return v;
  endfunction

  // kind 0: default pattern, kind 1: identity A / B[k][c]=10k+c; mode 0 sequential, 1 gapped concurrent
  task automatic drive_job(input int ni, input int nc, input int no, input int kind,
                           input int mode, input int extra);
    int ti, wi, n, ti_max, wi_max;
    ti = 0; wi = 0; n = 0;
    ti_max = ni * nc / 4;
    wi_max = nc * no / 4;
    seen_q.delete();
    num_in = 16'(ni); num_common = 16'(nc); num_out = 16'(no);
    while (ti < ti_max + extra || wi < wi_max) begin
      @(negedge clk);
      in_en = 1'b0;
      w_en  = 1'b0;
      if (ti < ti_max + extra && (mode == 0 || n % 3 != 2)) begin
        in_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
          if (ti >= ti_max)  in_data[r] = 16'(99 + ti + r);
          else if (kind == 0) in_data[r] = 16'((ti % 2 == 0) ? r + 1 : r + 5);
          else                in_data[r] = 16'((r == ti) ? 1 : 0);
        end
        ti++;
      end
      if (wi < wi_max && (mode == 0 ? (!in_en && ti >= ti_max + extra) : (n % 2 == 0))) begin
        w_en = 1'b1;
        for (int c = 0; c < 4; c++) w_data[c] = 16'((kind == 0) ? wi + c : 10*wi + c);
        wi++;
      end
      n++;
    end
    @(negedge clk);
    in_en = 1'b0;
    w_en  = 1'b0;
  endtask

  task automatic wait_rows(input int n);
    for (int i = 0; i < 2000 && seen_q.size() < n; i++) @(negedge clk);
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (out_rd_data !== '0) begin
      failures++;
      $display("FAIL reset_out got=%h exp=0", out_rd_data);
    end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (out_rd_data !== '0) begin
      failures++;
      $display("FAIL idle_out got=%h exp=0", out_rd_data);
    end
  endtask

  task automatic test_default;
    logic [3:0][31:0] fin;
    fin = {32'd1472, 32'd1424, 32'd1376, 32'd1328};
    drive_job(8, 8, 16, 0, 0, 0);
    wait_rows(32);
    checks++;
    if (seen_q.size() != 32) begin
      failures++;
      $display("FAIL default_count got=%0d exp=32", seen_q.size());
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (seen_q[i] !== exp_default(i)) begin
        failures++;
        $display("FAIL default_row%0d got=%h exp=%h", i, seen_q[i], exp_default(i));
      end
    end
    checks++;
    if (out_rd_data !== fin) begin
      failures++;
      $display("FAIL default_final got=%h exp=%h", out_rd_data, fin);
    end
  endtask

  task automatic test_extra_beats;
    drive_job(8, 8, 16, 0, 0, 4);
    wait_rows(32);
    checks++;
    if (seen_q.size() != 32) begin
      failures++;
      $display("FAIL extra_count got=%0d exp=32", seen_q.size());
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (seen_q[i] !== exp_default(i)) begin
        failures++;
        $display("FAIL extra_row%0d got=%h exp=%h", i, seen_q[i], exp_default(i));
      end
    end
  endtask

  task automatic test_interleaved;
    drive_job(8, 8, 16, 0, 1, 0);
    wait_rows(32);
    checks++;
    if (seen_q.size() != 32) begin
      failures++;
      $display("FAIL inter_count got=%0d exp=32", seen_q.size());
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (seen_q[i] !== exp_default(i)) begin
        failures++;
        $display("FAIL inter_row%0d got=%h exp=%h", i, seen_q[i], exp_default(i));
      end
    end
  endtask

  task automatic test_reset_mid_compute;
    drive_job(8, 8, 16, 0, 0, 0);
    for (int i = 0; i < 1000 && seen_q.size() < 2; i++) @(negedge clk);
    checks++;
    if (seen_q.size() < 2 || seen_q[0] !== exp_default(0)) begin
      failures++;
      $display("FAIL midrst_first got=%h exp=%h", (seen_q.size() > 0) ? seen_q[0] : '0, exp_default(0));
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (out_rd_data !== '0) begin
      failures++;
      $display("FAIL midrst_out got=%h exp=0", out_rd_data);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    drive_job(8, 8, 16, 0, 0, 0);
    wait_rows(32);
    checks++;
    if (seen_q.size() != 32) begin
      failures++;
      $display("FAIL midrst_count got=%0d exp=32", seen_q.size());
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (seen_q[i] !== exp_default(i)) begin
        failures++;
        $display("FAIL midrst_row%0d got=%h exp=%h", i, seen_q[i], exp_default(i));
      end
    end
  endtask

  task automatic test_identity;
    logic [3:0][31:0] exp;
    drive_job(4, 4, 4, 1, 0, 0);
    wait_rows(4);
    checks++;
    if (seen_q.size() != 4) begin
      failures++;
      $display("FAIL ident_count got=%0d exp=4", seen_q.size());
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) exp[c] = 32'(10*r + c);
      checks++;
      if (seen_q[r] !== exp) begin
        failures++;
        $display("FAIL ident_row%0d got=%h exp=%h", r, seen_q[r], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_extra_beats();
    test_interleaved();
    test_reset_mid_compute();
    test_identity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
